axi4_wr_burst_adapter: RTL
==========================

// Module: axi4_wr_burst_adapter
// PURPOSE
//  AXI4 write-slave front end for the DDR AXI4 arbiter write port; successor to the pass-through write interface.
//  Queues up to AW_FIFO_DEPTH write addresses, presents one burst request at a time to the arbiter,
//  gates W beats against AWLEN, and generates a proper B response carrying BID and BRESP.
//  Sits between an AXI4 master (video/codec DMA) and one arbiter write channel.
// PARAMETERS
//  AXI_DATA_WIDTH   64  W data width, bits
//  AXI_ADDR_WIDTH   32  AW address width, bits
//  AXI_ID_WIDTH      4  AWID/BID width
//  AW_FIFO_DEPTH     4  queued AW commands; power of 2, >=2
// PORTS
//  SYS_CLK_I       in   1    single clock; all logic rising-edge
//  RESET_I         in   1    synchronous, active-high reset
//  AWID_I          in   AXI_ID_WIDTH    write ID
//  AWADDR_I        in   AXI_ADDR_WIDTH  burst start address
//  AWLEN_I         in   8    beats minus one
//  AWVALID_I       in   1    AW valid
//  AWREADY_O       out  1    AW ready
//  WDATA_I         in   AXI_DATA_WIDTH  write data
//  WLAST_I         in   1    last beat marker
//  WVALID_I        in   1    W valid
//  WREADY_O        out  1    W ready
//  BID_O           out  AXI_ID_WIDTH    response ID
//  BRESP_O         out  2    00 OKAY, 10 SLVERR
//  BVALID_O        out  1    B valid
//  BREADY_I        in   1    B ready
//  BUSER_O         out  1    1-cycle pulse when arbiter reports burst done
//  W_REQ_O         out  1    burst request to arbiter
//  W_START_ADDR_O  out  AXI_ADDR_WIDTH  start address of requested burst
//  W_BURST_SIZE_O  out  8    beats minus one of requested burst
//  W_ACK_I         in   1    arbiter grant, 1-cycle pulse
//  W_DATA_O        out  AXI_DATA_WIDTH  data to arbiter (= WDATA_I)
//  W_DATA_VALID_O  out  1    WVALID_I & WREADY_O
//  W_DONE_I        in   1    arbiter burst complete, 1-cycle pulse
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; AWREADY_O=0 during reset, 1 the cycle after; WREADY_O, BVALID_O, W_REQ_O,
//   BUSER_O, W_DATA_VALID_O = 0; BID_O, BRESP_O, W_START_ADDR_O, W_BURST_SIZE_O = 0. Reset mid-burst drops all state.
//  AW: push on AWVALID_I&AWREADY_O; AWREADY_O = !full (registered count). Push+pop same cycle legal, count unchanged.
//  FSM (registered):
//   IDLE  -> REQ when FIFO non-empty; W_START_ADDR_O/W_BURST_SIZE_O/ID latched from FIFO head.
//   REQ   : W_REQ_O=1; -> DATA on W_ACK_I. Earliest W_REQ_O is 2 cycles after AW handshake.
//   DATA  : WREADY_O=1 (decoded from state, no lookahead); beat counter 0..len; W_DATA_VALID_O=WVALID_I.
//           Beat where count==len -> WAIT_DONE; if WLAST_I != (count==len) on any beat, set err flag.
//           WLAST_I early: beat still counted, transfer continues to len+1 beats (arbiter sees exact length).
//   WAIT_DONE: WREADY_O=0; -> RESP on W_DONE_I, or immediately if done already latched.
//   RESP  : BVALID_O=1, BID_O=latched ID, BRESP_O = err ? 2'b10 : 2'b00; held stable until BREADY_I;
//           on BVALID_O&BREADY_I: pop FIFO, clear err/done flags, -> IDLE.
//  W_DONE_I arriving in DATA (before last beat) is latched into done flag, not lost.
//  W_DONE_I outside DATA/WAIT_DONE: ignored. W_ACK_I outside REQ: ignored.
//  BUSER_O: registered, pulses 1 cycle after any accepted W_DONE_I.
//  Beat counter 8 bits, no wrap: len=255 gives 256 beats, count terminates at 255.
//  Back-to-back: next burst's REQ no earlier than cycle after B handshake (one burst in flight).
// STRUCTURE
//  Package axi4_wr_adapter_pkg: state enum {IDLE,REQ,DATA,WAIT_DONE,RESP}, BRESP_OKAY=2'b00, BRESP_SLVERR=2'b10.
//  Sub-module aw_cmd_fifo: sync FIFO, width AXI_ID_WIDTH+AXI_ADDR_WIDTH+8, depth AW_FIFO_DEPTH,
//   registered full/empty, first-word-fall-through head.
//  Top: FSM, beat counter, err/done flags, B registers.
// TESTING
//  1 Reset then AW id=3 addr=0x1000 len=3, 4 beats WLAST on 4th, ACK/DONE prompt -> W_REQ_O addr 0x1000 size 3, 4 W_DATA_VALID_O, BID=3 BRESP=00.
//  2 Push 5 AWs with no ACK, depth 4 -> AWREADY_O low after 4th; 5th accepted only after first B handshake.
//  3 len=1 with WLAST on beat 0 -> 2 beats forwarded, BRESP=10; next burst OKAY (flag cleared).
//  4 W_DONE_I pulsed during beat 2 of len=3 -> BVALID_O asserted cycle after last beat; BUSER_O single pulse.
//  5 BREADY_I held low 10 cycles -> BVALID_O/BID_O/BRESP_O stable; no new W_REQ_O until handshake.
//  6 RESET_I asserted mid-DATA of len=255 -> next cycle all outputs at reset values, FIFO empty; new burst completes OKAY.

Source files
------------

// File: rtl/axi4_wr_adapter_pkg.sv
// Shared types for the AXI4 write burst adapter.
// Burst FSM state encoding and B response codes.
package axi4_wr_adapter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DATA,
      WAIT_DONE,
      RESP
   } state_t;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/aw_cmd_fifo.sv
// AW command queue: synchronous FIFO with registered empty/ready
// and a first-word-fall-through head.
module aw_cmd_fifo #(
   parameter int WIDTH = 44,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_nxt;
   logic             empty_q;
   logic             ready_q;

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop) begin
         cnt_nxt = cnt + (AW+1)'(1);
      end else if (pop && !push) begin
         cnt_nxt = cnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= din;
      end
   end

   // ready is held low through reset so no AW is taken while reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         empty_q <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         cnt     <= cnt_nxt;
         empty_q <= (cnt_nxt == '0);
         ready_q <= (cnt_nxt != FULL_CNT);
      end
   end

   assign head  = mem[rp];
   assign empty = empty_q;
   assign ready = ready_q;

endmodule

// File: rtl/axi4_wr_burst_adapter.sv
// AXI4 write-slave front end: queues AW commands, requests one burst
// at a time from the arbiter, gates W beats against AWLEN, returns B.
module axi4_wr_burst_adapter
   import axi4_wr_adapter_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AW_FIFO_DEPTH  = 4
) (
   input  logic                      SYS_CLK_I,
   input  logic                      RESET_I,
   input  logic [AXI_ID_WIDTH-1:0]   AWID_I,
   input  logic [AXI_ADDR_WIDTH-1:0] AWADDR_I,
   input  logic [7:0]                AWLEN_I,
   input  logic                      AWVALID_I,
   output logic                      AWREADY_O,
   input  logic [AXI_DATA_WIDTH-1:0] WDATA_I,
   input  logic                      WLAST_I,
   input  logic                      WVALID_I,
   output logic                      WREADY_O,
   output logic [AXI_ID_WIDTH-1:0]   BID_O,
   output logic [1:0]                BRESP_O,
   output logic                      BVALID_O,
   input  logic                      BREADY_I,
   output logic                      BUSER_O,
   output logic                      W_REQ_O,
   output logic [AXI_ADDR_WIDTH-1:0] W_START_ADDR_O,
   output logic [7:0]                W_BURST_SIZE_O,
   input  logic                      W_ACK_I,
   output logic [AXI_DATA_WIDTH-1:0] W_DATA_O,
   output logic                      W_DATA_VALID_O,
   input  logic                      W_DONE_I
);

   localparam int CW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8;

   state_t state;
   state_t state_nxt;

   logic [CW-1:0]             head;
   logic                      fifo_empty;
   logic                      aw_rdy;
   logic                      aw_push;
   logic                      b_fire;
   logic                      beat;
   logic                      last;
   logic                      beat_err;
   logic                      done_in;
   logic                      w_req;
   logic                      w_rdy;
   logic                      b_vld;

   logic [7:0]                cnt;
   logic                      err_q;
   logic                      done_q;
   logic                      buser_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                size_q;
   logic [1:0]                bresp_q;

   aw_cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (AW_FIFO_DEPTH)
   ) u_aw_fifo (
      .clk   (SYS_CLK_I),
      .rst   (RESET_I),
      .push  (aw_push),
      .din   ({AWID_I, AWADDR_I, AWLEN_I}),
      .pop   (b_fire),
      .head  (head),
      .empty (fifo_empty),
      .ready (aw_rdy)
   );

   assign aw_push  = AWVALID_I & aw_rdy;
   assign beat     = WVALID_I & w_rdy;
   assign last     = (cnt == size_q);
   assign beat_err = beat & (WLAST_I != last);
   assign done_in  = W_DONE_I & ((state == DATA) | (state == WAIT_DONE));
   assign b_fire   = b_vld & BREADY_I;

   always_ff @(posedge SYS_CLK_I) begin
      if (RESET_I) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      w_req     = 1'b0;
      w_rdy     = 1'b0;
      b_vld     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) state_nxt = REQ;
         end
         REQ: begin
            w_req = 1'b1;
            if (W_ACK_I) state_nxt = DATA;
         end
         DATA: begin
            w_rdy = 1'b1;
            if (beat && last) begin
               state_nxt = (done_q || W_DONE_I) ? RESP : WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (done_q || W_DONE_I) state_nxt = RESP;
         end
         RESP: begin
            b_vld = 1'b1;
            if (BREADY_I) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A WLAST mismatch on the final beat must still reach BRESP
   always_ff @(posedge SYS_CLK_I) begin
      if (RESET_I) begin
         cnt     <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         buser_q <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         bresp_q <= BRESP_OKAY;
      end else begin
         buser_q <= done_in;
         if (state == IDLE && !fifo_empty) begin
            {id_q, addr_q, size_q} <= head;
         end
         if (beat) begin
            cnt <= last ? 8'd0 : cnt + 8'd1;
         end
         if (beat_err) begin
            err_q <= 1'b1;
         end
         if (done_in) begin
            done_q <= 1'b1;
         end
         if (state_nxt == RESP && state != RESP) begin
            bresp_q <= (err_q || beat_err) ? BRESP_SLVERR : BRESP_OKAY;
         end
         if (b_fire) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
         end
      end
   end

   assign AWREADY_O      = aw_rdy;
   assign WREADY_O       = w_rdy;
   assign W_REQ_O        = w_req;
   assign BVALID_O       = b_vld;
   assign BID_O          = id_q;
   assign BRESP_O        = bresp_q;
   assign BUSER_O        = buser_q;
   assign W_START_ADDR_O = addr_q;
   assign W_BURST_SIZE_O = size_q;
   assign W_DATA_O       = WDATA_I;
   assign W_DATA_VALID_O = beat;

endmodule
